dcache_req_queue: RTL and testbench
===================================

Name: dcache_req_queue

Overview:
- Parametrised multi-entry request queue between the LSU issue stage and the Dcache pipeline. It replaces the single-entry request buffer.
- Holds up to DEPTH memory requests (addr, data, opcode, pc, opflag, type, wstrb) in FIFO order, with a valid/ready handshake on both sides.
- Supports a late SUC (store-conditional success) flag that arrives one cycle after its request is pushed, plus a synchronous flush.

Parameters:
DEPTH, 4, number of entries; power of 2, at least 2
AW, 32, address width
DW, 32, store data width
OPW, 32, opcode width
PCW, 32, pc width
CW, $clog2(DEPTH+1), width of the count output

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of all entries and the pending SUC window
in_valid  in  1  push request
in_ready  out  1  queue can accept a push
in_addr  in  AW  request address
in_data  in  DW  store data
in_opcode  in  OPW  opcode
in_pc  in  PCW  pc of the instruction
in_opflag  in  1  op flag
in_type  in  1  request type
in_wstrb  in  4  byte strobes
in_suc  in  1  late SUC for the request pushed in the previous cycle
out_valid  out  1  head entry valid
out_ready  in  1  consumer takes the head
out_addr, out_data, out_opcode, out_pc, out_opflag, out_type, out_wstrb  out  AW/DW/OPW/PCW/1/1/4  head entry fields
out_suc  out  1  head entry SUC, with same-cycle bypass
count  out  CW  number of occupied entries

Behaviour:
- Reset (rstn=0, asynchronous):
  - head, tail, count=0; all storage (including suc bits) =0; pend_valid=0.
  - Outputs: out_valid=0, in_ready=1, count=0, all out_* fields =0.
- Push: occurs when in_valid && in_ready.
  - in_ready = (count < DEPTH). It does not depend on out_ready; a push into a full queue is never accepted, even when a pop happens in the same cycle.
  - On a push, the entry at tail is written with all in_* fields and suc=0; tail increments modulo DEPTH (natural wrap).
- Pop: occurs when out_valid && out_ready; head increments modulo DEPTH.
- out_valid = (count != 0). There is no fall-through: a request pushed at edge N is visible at the head no earlier than after edge N.
- Output fields:
  - out_* are driven combinationally from entry[head], gated to 0 when out_valid=0.
  - out_opflag and out_type follow the same rule.
- Count:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged; both pointers advance.
- Late SUC window:
  - A push sets pend_valid<=1 and pend_idx<=tail; a cycle without a push clears pend_valid.
  - In the cycle where pend_valid=1: entry[pend_idx].suc <= in_suc. This write is skipped if that entry is popped in the same cycle.
  - in_suc is ignored when pend_valid=0.
- Bypass: out_suc = entry[head].suc | (pend_valid && pend_idx==head && in_suc).
  - This lets a consumer popping the entry in its SUC cycle see the correct value.
- Back-to-back pushes: every push opens a new one-cycle window for its own entry. Windows never overlap.
- Flush (synchronous, highest priority over push/pop):
  - head, tail, count<=0; pend_valid<=0.
  - A push in the flush cycle is discarded and in_suc in that cycle is ignored.
  - Storage contents are not cleared (gated by out_valid).
- Reset asserted mid-operation: immediate return to the reset state. No entry survives.
- DEPTH entries full: in_ready=0, and stays 0 until a pop or flush.
- Empty with out_ready=1: no state change.

Test Plan:
- Push 3 requests (addr 0x100, 0x104, 0x108) while out_ready=0 -> count=3, out_addr=0x100. Then raise out_ready for 3 cycles -> out_addr sequence 0x100, 0x104, 0x108, then out_valid=0 and out_addr=0.
- Fill DEPTH=4 entries -> in_ready=0. Hold in_valid=1 with out_ready=1 for one cycle -> pop only, count=3; next cycle in_ready=1 and the held push is accepted. Run 10 push/pop pairs -> pointers wrap with FIFO order intact.
- Push addr 0x200 with opcode SC, in_suc=1 the next cycle, queue non-empty ahead of it -> when 0x200 reaches the head, out_suc=1. Repeat with in_suc=0 -> out_suc=0. Drive in_suc=1 in a cycle with no pending window -> no entry changes.
- Empty queue: push SC at edge N; at cycle N+1, out_ready=1 and in_suc=1 -> pop with out_suc=1 (bypass). Queue empty afterwards; no stale suc write to the recycled slot (push a new entry there -> out_suc=0).
- count=3, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, and the concurrent push is lost.
- Assert rstn=0 asynchronously mid-stream with count=2 -> outputs zero immediately (out_valid=0, count=0). After release, a fresh push of 0x300 appears at the head one cycle later.

Source files
------------

// File: rtl/dcache_req_queue.sv
// FIFO of pending LSU memory requests feeding the Dcache pipeline.
// A store-conditional success flag can be attached one cycle after its push.
module dcache_req_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int OPW   = 32,
  parameter int PCW   = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           flush,

  input  logic           in_valid,
  output logic           in_ready,
  input  logic [AW-1:0]  in_addr,
  input  logic [DW-1:0]  in_data,
  input  logic [OPW-1:0] in_opcode,
  input  logic [PCW-1:0] in_pc,
  input  logic           in_opflag,
  input  logic           in_type,
  input  logic [3:0]     in_wstrb,
  input  logic           in_suc,

  output logic           out_valid,
  input  logic           out_ready,
  output logic [AW-1:0]  out_addr,
  output logic [DW-1:0]  out_data,
  output logic [OPW-1:0] out_opcode,
  output logic [PCW-1:0] out_pc,
  output logic           out_opflag,
  output logic           out_type,
  output logic [3:0]     out_wstrb,
  output logic           out_suc,

  output logic [CW-1:0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [PW-1:0]  pend_idx;
  logic           pend_valid;
  logic [CW-1:0]  count_q;

  logic [AW-1:0]  addr_mem   [DEPTH];
  logic [DW-1:0]  data_mem   [DEPTH];
  logic [OPW-1:0] opcode_mem [DEPTH];
  logic [PCW-1:0] pc_mem     [DEPTH];
  logic           opflag_mem [DEPTH];
  logic           type_mem   [DEPTH];
  logic [3:0]     wstrb_mem  [DEPTH];
  logic           suc_mem    [DEPTH];

  logic push;
  logic pop;
  logic suc_wr;
  logic suc_bypass;

  // Full blocks pushes even when a pop happens in the same cycle.
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push   = in_valid && in_ready && !flush;
  assign pop    = out_valid && out_ready && !flush;
  assign suc_wr = pend_valid && !flush && !(pop && (pend_idx == head));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (push) begin
        tail     <= tail + PW'(1);
        pend_idx <= tail;
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      pend_valid <= push;
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i]   <= '0;
        data_mem[i]   <= '0;
        opcode_mem[i] <= '0;
        pc_mem[i]     <= '0;
        opflag_mem[i] <= 1'b0;
        type_mem[i]   <= 1'b0;
        wstrb_mem[i]  <= '0;
      end
    end else if (push) begin
      addr_mem[tail]   <= in_addr;
      data_mem[tail]   <= in_data;
      opcode_mem[tail] <= in_opcode;
      pc_mem[tail]     <= in_pc;
      opflag_mem[tail] <= in_opflag;
      type_mem[tail]   <= in_type;
      wstrb_mem[tail]  <= in_wstrb;
    end
  end

  // The pending slot never equals tail on a push, so both writes can coexist.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        suc_mem[i] <= 1'b0;
      end
    end else begin
      if (suc_wr) begin
        suc_mem[pend_idx] <= in_suc;
      end
      if (push) begin
        suc_mem[tail] <= 1'b0;
      end
    end
  end

  assign suc_bypass = pend_valid && (pend_idx == head) && in_suc;

  assign out_addr   = out_valid ? addr_mem[head]   : '0;
  assign out_data   = out_valid ? data_mem[head]   : '0;
  assign out_opcode = out_valid ? opcode_mem[head] : '0;
  assign out_pc     = out_valid ? pc_mem[head]     : '0;
  assign out_opflag = out_valid ? opflag_mem[head] : 1'b0;
  assign out_type   = out_valid ? type_mem[head]   : 1'b0;
  assign out_wstrb  = out_valid ? wstrb_mem[head]  : '0;
  assign out_suc    = out_valid ? (suc_mem[head] | suc_bypass) : 1'b0;

endmodule

// File: tb/tb_dcache_req_queue.sv
// Directed bench for dcache_req_queue (DEPTH=4): ordering, backpressure,
// late SUC writes and bypass, flush and asynchronous reset.
module tb_dcache_req_queue;

  localparam logic [31:0] OP_LD = 32'h0000_0003;
  localparam logic [31:0] OP_SC = 32'h0000_002F;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [31:0] in_opcode;
  logic [31:0] in_pc;
  logic        in_opflag;
  logic        in_type;
  logic [3:0]  in_wstrb;
  logic        in_suc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [31:0] out_opcode;
  logic [31:0] out_pc;
  logic        out_opflag;
  logic        out_type;
  logic [3:0]  out_wstrb;
  logic        out_suc;
  logic [2:0]  count;

  int tests_run;
  int tests_failed;

  dcache_req_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_opcode  (in_opcode),
    .in_pc      (in_pc),
    .in_opflag  (in_opflag),
    .in_type    (in_type),
    .in_wstrb   (in_wstrb),
    .in_suc     (in_suc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_opcode (out_opcode),
    .out_pc     (out_pc),
    .out_opflag (out_opflag),
    .out_type   (out_type),
    .out_wstrb  (out_wstrb),
    .out_suc    (out_suc),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Side fields are derived from the address so every field is checkable.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] pc_of(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] a,
                               input logic [31:0] opc, input logic suc,
                               input logic ordy, input logic fl);
    in_valid  = v;
    in_addr   = a;
    in_data   = data_of(a);
    in_opcode = opc;
    in_pc     = pc_of(a);
    in_opflag = a[2];
    in_type   = a[3];
    in_wstrb  = a[5:2];
    in_suc    = suc;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("[TB] %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_addr;
    tests_run    = 0;
    tests_failed = 0;
    rstn = 1'b0;
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_count", {29'b0, count}, 32'd0);
    checkOutput("rst_out_addr", out_addr, 32'd0);
    checkOutput("rst_out_suc", {31'b0, out_suc}, 32'd0);
    rstn = 1'b1;
    tick();

    // Three pushes with the consumer stalled, then drain in order.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), OP_LD, 1'b0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b0, 1'b0);
    checkOutput("fill3_count", {29'b0, count}, 32'd3);
    checkOutput("fill3_addr", out_addr, 32'h100);
    checkOutput("fill3_data", out_data, 32'hA5A5_0100);
    checkOutput("fill3_pc", out_pc, 32'h1000_0100);
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("drain3_addr", out_addr, 32'h100 + 32'(4 * i));
      tick();
    end
    checkOutput("drain3_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("drain3_addr0", out_addr, 32'd0);

    // Fill to DEPTH, check a pop-only cycle with a held push, then wrap.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h400 + 32'(4 * i), OP_LD, 1'b0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b0, 1'b0);
    checkOutput("full_count", {29'b0, count}, 32'd4);
    checkOutput("full_in_ready", {31'b0, in_ready}, 32'd0);
    applyStimulus(1'b1, 32'h410, OP_LD, 1'b0, 1'b1, 1'b0);
    checkOutput("full_pop_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("full_pop_head", out_addr, 32'h400);
    tick();
    applyStimulus(1'b1, 32'h410, OP_LD, 1'b0, 1'b0, 1'b0);
    checkOutput("pop_only_count", {29'b0, count}, 32'd3);
    checkOutput("pop_only_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("pop_only_head", out_addr, 32'h404);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b1, 1'b0);
    checkOutput("held_push_count", {29'b0, count}, 32'd4);
    checkOutput("drain2_a", out_addr, 32'h404);
    tick();
    checkOutput("drain2_b", out_addr, 32'h408);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h500 + 32'(4 * i), OP_LD, 1'b0, 1'b1, 1'b0);
      exp_addr = (i < 2) ? 32'h40C + 32'(4 * i) : 32'h500 + 32'(4 * (i - 2));
      checkOutput("wrap_order", out_addr, exp_addr);
      tick();
    end
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b1, 1'b0);
    checkOutput("wrap_count", {29'b0, count}, 32'd2);
    checkOutput("wrap_tail_a", out_addr, 32'h520);
    checkOutput("wrap_tail_wstrb", {28'b0, out_wstrb}, 32'h8);
    tick();
    checkOutput("wrap_tail_b", out_addr, 32'h524);
    checkOutput("wrap_tail_opflag", {31'b0, out_opflag}, 32'd1);
    tick();
    checkOutput("wrap_empty", {29'b0, count}, 32'd0);

    // Late SUC=1 for 0x200 queued behind 0x1F0.
    applyStimulus(1'b1, 32'h1F0, OP_LD, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h200, OP_SC, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b1, 1'b0, 1'b0);
    checkOutput("suc1_head_suc", {31'b0, out_suc}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b1, 1'b0);
    checkOutput("suc1_head_addr", out_addr, 32'h1F0);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b0, 1'b0);
    checkOutput("suc1_sc_addr", out_addr, 32'h200);
    checkOutput("suc1_sc_opcode", out_opcode, OP_SC);
    checkOutput("suc1_sc_suc", {31'b0, out_suc}, 32'd1);
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b1, 1'b0);
    tick();

    // Late SUC=0, then a stray in_suc=1 with no window open.
    applyStimulus(1'b1, 32'h1F4, OP_LD, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h210, OP_SC, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b0, 1'b0);
    checkOutput("suc0_head_suc", {31'b0, out_suc}, 32'd0);
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b0, 1'b0);
    checkOutput("suc0_sc_addr", out_addr, 32'h210);
    checkOutput("suc0_sc_suc", {31'b0, out_suc}, 32'd0);
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b1, 1'b0);
    tick();

    // Pop in the SUC cycle itself: value comes through the bypass.
    applyStimulus(1'b1, 32'h220, OP_SC, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b1, 1'b1, 1'b0);
    checkOutput("bypass_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("bypass_suc", {31'b0, out_suc}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b0, 1'b0);
    checkOutput("bypass_empty", {29'b0, count}, 32'd0);
    checkOutput("bypass_empty_suc", {31'b0, out_suc}, 32'd0);
    applyStimulus(1'b1, 32'h230, OP_SC, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b0, 1'b0);
    checkOutput("recycle_addr", out_addr, 32'h230);
    checkOutput("recycle_suc", {31'b0, out_suc}, 32'd0);
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b1, 1'b0);
    tick();

    // Flush with a concurrent push: everything is dropped.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h600 + 32'(4 * i), OP_LD, 1'b0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 32'h6FC, OP_LD, 1'b1, 1'b0, 1'b1);
    checkOutput("preflush_count", {29'b0, count}, 32'd3);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_count", {29'b0, count}, 32'd0);
    checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("flush_addr", out_addr, 32'd0);
    applyStimulus(1'b1, 32'h610, OP_LD, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b0, 1'b0);
    checkOutput("postflush_count", {29'b0, count}, 32'd1);
    checkOutput("postflush_addr", out_addr, 32'h610);
    checkOutput("postflush_type", {31'b0, out_type}, 32'd0);

    // Asynchronous reset in the middle of a cycle.
    applyStimulus(1'b1, 32'h700, OP_LD, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b0, 1'b0);
    checkOutput("prerst_count", {29'b0, count}, 32'd2);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("arst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("arst_count", {29'b0, count}, 32'd0);
    checkOutput("arst_addr", out_addr, 32'd0);
    checkOutput("arst_ready", {31'b0, in_ready}, 32'd1);
    #2;
    rstn = 1'b1;
    tick();
    applyStimulus(1'b1, 32'h300, OP_LD, 1'b0, 1'b0, 1'b0);
    checkOutput("fresh_not_yet", {31'b0, out_valid}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, OP_LD, 1'b0, 1'b0, 1'b0);
    checkOutput("fresh_addr", out_addr, 32'h300);
    checkOutput("fresh_count", {29'b0, count}, 32'd1);
    checkOutput("fresh_wstrb", {28'b0, out_wstrb}, 32'h0);
    checkOutput("fresh_data", out_data, 32'hA5A5_0300);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
